// File: rtl/apb_master_arbiter_if.sv
// Requester command/response channels plus the APB master-side bus signals.
// The arbiter uses the master modport; requesters and the slave model use the slave modport.
interface apb_master_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
);
    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [1:0]              req_write;
    logic [2*ADDR_WIDTH-1:0] req_addr;
    logic [2*DATA_WIDTH-1:0] req_wdata;
    logic [1:0]              rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic                    PENABLE;
    logic                    PnR_W;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic                    PREADY;
    logic [DATA_WIDTH-1:0]   PRDATA;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, PENABLE, PnR_W, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, PENABLE, PnR_W, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin command accept, SETUP/ACCESS sequencing,
// PREADY wait with timeout abort, and per-requester response strobe.
module apb_master_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_master_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state, state_next;
    logic                  sel;
    logic                  grant;
    logic                  last_grant;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            req_ready_c;
    logic [1:0]            rsp_valid_c;
    logic                  penable_c;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // A tie goes to whoever was not served last; a lone request simply wins.
    always_comb begin
        sel       = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];
        sel_addr  = sel ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.req_addr[ADDR_WIDTH-1:0];
        sel_wdata = sel ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_wdata[DATA_WIDTH-1:0];
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_ready_c = '0;
        rsp_valid_c = '0;
        penable_c   = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req_valid && !PRESET) begin
                    req_ready_c = sel ? 2'b10 : 2'b01;
                    state_next  = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                penable_c = 1'b1;
                if (bus.PREADY || cnt == CNT_LAST) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid_c = grant ? 2'b10 : 2'b01;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.PENABLE   = penable_c;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            cnt           <= '0;
            bus.PnR_W     <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        grant     <= sel;
                        bus.PADDR <= sel_addr;
                        bus.PnR_W <= bus.req_write[sel];
                        if (bus.req_write[sel]) begin
                            bus.PWDATA <= sel_wdata;
                        end
                    end
                end
                SETUP: begin
                    cnt <= '0;
                end
                ACCESS: begin
                    // PREADY is checked first so a late ready still beats the timeout.
                    if (bus.PREADY) begin
                        if (!bus.PnR_W) begin
                            bus.rsp_rdata <= bus.PRDATA;
                        end
                        bus.rsp_err <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    last_grant <= grant;
                end
                default: ;
            endcase
        end
    end
endmodule
